mem_req_scheduler: RTL
======================

// Module: mem_req_scheduler
// PURPOSE
//   Shares the single memory port between instruction fetch (read-only line fills) and
//   the TLB/data side (line reads and write-backs). Latches the winning request, holds it
//   stable at the memory until serviceReady, then routes the completion pulse back.
//   Conflicts alternate winners. Sits between fetch/tlblookup_stage and memory in proc.
// PARAMETERS
//   addr_width        16    width of every address port
//   cache_line_width  256   width of the write-data line
//   WDOG_CYCLES       64    watchdog limit in cycles; only with MEM_SCHED_WDOG_EN
// PORTS
//   clk                clk     in   1       single clock, rising edge
//   reset              reset   in   1       synchronous, active-high
//   petitionInstr      in   1                  fetch request; held until serviceReadyInstr
//   addressInstr       in   addr_width         fetch line address
//   serviceReadyInstr  out  1                  1-cycle completion pulse to fetch
//   petitionDat        in   1                  data request; held until serviceReadyDat
//   addressDat         in   addr_width         data line address
//   weDat              in   1                  1 = write-back, 0 = line read
//   dataWriteDat       in   cache_line_width   write-back line
//   serviceReadyDat    out  1                  1-cycle completion pulse to data side
//   petitionMem        out  1                  request to memory
//   addressMem         out  addr_width         latched address
//   weMem              out  1                  latched write enable; 0 for instr grants
//   dataWriteMem       out  cache_line_width   latched write line
//   serviceReadyMem    in   1                  memory completion
//   busy               out  1                  1 in any state other than IDLE
//   grantDat           out  1                  1 while a data transaction owns memory
//   timeout            out  1                  watchdog abort pulse; tied 0 without macro
// BEHAVIOUR
//   Reset: state=IDLE, lastGrantDat=0; all outputs 0, latched addr/data/we cleared to 0.
//   States: IDLE, GNT_I, GNT_D, RELEASE. petitionMem/busy/grantDat are Moore outputs.
//   IDLE: only petitionInstr -> GNT_I; only petitionDat -> GNT_D.
//     Both -> the one not served last: lastGrantDat=1 -> GNT_I, else GNT_D.
//     After reset, data wins the first conflict.
//     On the grant edge, latch address/we/data: instr -> weMem=0, dataWriteMem unchanged.
//   GNT_x: petitionMem=1; addressMem/weMem/dataWriteMem held stable.
//     serviceReadyMem=1 -> serviceReady_x=1 in the same cycle (combinational with state).
//     Same edge: set lastGrantDat, go to RELEASE.
//   RELEASE: petitionMem=0 for exactly 1 cycle -> IDLE. Petitions are not sampled.
//     Requesters drop petition in this cycle.
//   Latency: petition at cycle t in IDLE -> petitionMem=1 at t+1.
//     Ready at cycle k -> next grant earliest at k+3.
//   serviceReadyMem while in IDLE or RELEASE is ignored; no serviceReady_x pulse.
//   Requester drops petition mid-grant: the transaction still completes and pulses.
//   The late pulse is harmless to the requester.
//   Input changes on addressX/weDat/dataWriteDat during a grant have no effect.
//   Never pulse serviceReadyInstr and serviceReadyDat in the same cycle.
//   Reset asserted mid-grant: next edge state=IDLE, petitionMem=0. Transaction abandoned.
// CONFIGURATION
//   MEM_SCHED_WDOG_EN defined: an 8-bit counter clears on entering GNT_x and counts
//     each GNT_x cycle without serviceReadyMem.
//     Count reaches WDOG_CYCLES-1 -> timeout=1 for 1 cycle.
//     That requester gets serviceReady_x=1 (abort), then RELEASE as normal.
//   Not defined: no counter; timeout is constant 0; GNT_x waits indefinitely.
// TESTING
//   Lone instr petition, addr 0x000C, memory ready 4 cycles after petitionMem ->
//     petitionMem rises at t+1, addressMem=0x000C, weMem=0, serviceReadyInstr pulses once.
//   Both petition at the first cycle after reset ->
//     data granted first, instr granted at ready+3; a third conflict goes to data.
//   Data write, addressDat=0x0040, weDat=1, line=256'hA5..A5; change inputs mid-grant ->
//     memory sees 0x0040/we=1/A5 line unchanged until serviceReadyMem.
//   Spurious serviceReadyMem in IDLE and in RELEASE -> no serviceReady pulse, state unchanged.
//   Reset raised 2 cycles into GNT_D -> next cycle IDLE, petitionMem=0, grantDat=0, busy=0.
//   With MEM_SCHED_WDOG_EN, WDOG_CYCLES=8, memory never ready ->
//     timeout and serviceReadyDat pulse 8 cycles after grant, then IDLE 2 cycles later.

Source files
------------

// File: rtl/mem_req_scheduler.sv
// Arbitrates the single memory port between instruction fetch and the data/TLB side,
// holding the granted request stable until memory completes. Watchdog: MEM_SCHED_WDOG_EN.
module mem_req_scheduler #(
  parameter int ADDR_WIDTH       = 16,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int WDOG_CYCLES      = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        petitionInstr_i,
  input  logic [ADDR_WIDTH-1:0]       addressInstr_i,
  output logic                        serviceReadyInstr_o,
  input  logic                        petitionDat_i,
  input  logic [ADDR_WIDTH-1:0]       addressDat_i,
  input  logic                        weDat_i,
  input  logic [CACHE_LINE_WIDTH-1:0] dataWriteDat_i,
  output logic                        serviceReadyDat_o,
  output logic                        petitionMem_o,
  output logic [ADDR_WIDTH-1:0]       addressMem_o,
  output logic                        weMem_o,
  output logic [CACHE_LINE_WIDTH-1:0] dataWriteMem_o,
  input  logic                        serviceReadyMem_i,
  output logic                        busy_o,
  output logic                        grantDat_o,
  output logic                        timeout_o
);

  // state   | meaning
  // IDLE    | no owner; petitions sampled and arbitrated
  // GNT_I   | fetch owns memory, request held stable
  // GNT_D   | data side owns memory, request held stable
  // RELEASE | one-cycle gap so requesters can drop their petitions
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_e;

  state_e                      state_q;
  logic                        last_grant_dat_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        we_q;
  logic [CACHE_LINE_WIDTH-1:0] data_q;
  logic                        in_gnt;
  logic                        wdog_fire;
  logic                        done;

  assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

`ifdef MEM_SCHED_WDOG_EN
  logic [7:0] wdog_q;

  assign wdog_fire = in_gnt && !serviceReadyMem_i && (wdog_q == 8'(WDOG_CYCLES - 1));

  // Cleared while IDLE, which every grant passes through, so it starts at 0 in GNT_x.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wdog_q <= 8'd0;
    end else if (state_q == IDLE) begin
      wdog_q <= 8'd0;
    end else if (in_gnt && !serviceReadyMem_i) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  assign done = in_gnt && (serviceReadyMem_i || wdog_fire);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      last_grant_dat_q <= 1'b0;
      addr_q           <= '0;
      we_q             <= 1'b0;
      data_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (petitionInstr_i && (!petitionDat_i || last_grant_dat_q)) begin
            state_q <= GNT_I;
            addr_q  <= addressInstr_i;
            we_q    <= 1'b0;
          end else if (petitionDat_i) begin
            state_q <= GNT_D;
            addr_q  <= addressDat_i;
            we_q    <= weDat_i;
            data_q  <= dataWriteDat_i;
          end
        end
        GNT_I: begin
          if (done) begin
            last_grant_dat_q <= 1'b0;
            state_q          <= RELEASE;
          end
        end
        GNT_D: begin
          if (done) begin
            last_grant_dat_q <= 1'b1;
            state_q          <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign petitionMem_o       = in_gnt;
  assign busy_o              = (state_q != IDLE);
  assign grantDat_o          = (state_q == GNT_D);
  assign addressMem_o        = addr_q;
  assign weMem_o             = we_q;
  assign dataWriteMem_o      = data_q;
  assign serviceReadyInstr_o = done && (state_q == GNT_I);
  assign serviceReadyDat_o   = done && (state_q == GNT_D);
  assign timeout_o           = wdog_fire;

endmodule
